// File: rtl/sim_run_ctrl_if.sv
// Bundle of per-core monitor inputs and run/verdict outputs of the simulation run controller.
// The bench side drives the core channels (master); the controller consumes them (slave).
interface sim_run_ctrl_if #(
  parameter int N_CORES = 1,
  parameter int CNT_W   = 32
);
  logic [N_CORES-1:0] halt;
  logic [N_CORES-1:0] error;
  logic [N_CORES-1:0] activity;
  logic               cpu_rst;
  logic               run;
  logic               sim_end;
  logic               pass;
  logic [2:0]         status;
  logic [CNT_W-1:0]   cycle_count;
  logic [N_CORES-1:0] halted_mask;

  modport master (
    output halt, error, activity,
    input  cpu_rst, run, sim_end, pass, status, cycle_count, halted_mask
  );

  modport slave (
    input  halt, error, activity,
    output cpu_rst, run, sim_end, pass, status, cycle_count, halted_mask
  );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run controller for the CPU simulation harness: sequences CPU reset, counts run cycles,
// ends the run on pass/error/timeout/stall and raises sim_end after a drain window.
module sim_run_ctrl #(
  parameter int N_CORES        = 1,
  parameter int CNT_W          = 32,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 300,
  parameter int STALL_CYCLES   = 64,
  parameter int DRAIN_CYCLES   = 4
) (
  input logic          clka,
  input logic          rst,
  sim_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef enum logic [2:0] {
    ST_NONE    = 3'd0,
    ST_PASS    = 3'd1,
    ST_ERROR   = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_STALL   = 3'd4
  } verdict_t;

  localparam int RST_N   = (RST_CYCLES   < 1) ? 1 : RST_CYCLES;
  localparam int DRAIN_N = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;

  // Terminal counter values; the timeout/stall ones are only compared when enabled.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_N - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_N - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST   = CNT_W'(STALL_CYCLES - 1);

  state_t             state, state_next;
  verdict_t           status, status_next;
  logic [CNT_W-1:0]   phase_cnt;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic [N_CORES-1:0] halted_mask;

  logic any_activity, new_halt;
  logic hit_error, hit_pass, hit_timeout, hit_stall;

  assign any_activity = |bus.activity;
  assign new_halt     = |(bus.halt & ~halted_mask);
  assign hit_error    = |bus.error;
  assign hit_pass     = &(halted_mask | bus.halt);
  assign hit_timeout  = (TIMEOUT_CYCLES != 0) && (cycle_cnt == TIMEOUT_LAST);
  assign hit_stall    = (STALL_CYCLES != 0) && (stall_cnt == STALL_LAST) && !any_activity;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state  <= S_RESET;
      status <= ST_NONE;
    end else begin
      state  <= state_next;
      status <= status_next;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
  always_comb begin
    state_next  = state;
    status_next = status;
    unique case (state)
      S_RESET: if (phase_cnt == RST_LAST) state_next = S_RUN;
      S_RUN: begin
        // Priority error > pass > timeout > stall.
        if (hit_error) begin
          status_next = ST_ERROR;
          state_next  = S_DRAIN;
        end else if (hit_pass) begin
          status_next = ST_PASS;
          state_next  = S_DRAIN;
        end else if (hit_timeout) begin
          status_next = ST_TIMEOUT;
          state_next  = S_DRAIN;
        end else if (hit_stall) begin
          status_next = ST_STALL;
          state_next  = S_DRAIN;
        end
      end
      S_DRAIN: if (phase_cnt == DRAIN_LAST) state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_RESET;
    endcase
  end

  // Counters and sticky halt record; only RUN lets the core channels in.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      phase_cnt   <= '0;
      cycle_cnt   <= '0;
      stall_cnt   <= '0;
      halted_mask <= '0;
    end else begin
      unique case (state)
        S_RESET: phase_cnt <= (phase_cnt == RST_LAST) ? '0 : phase_cnt + 1'b1;
        S_RUN: begin
          phase_cnt   <= '0;
          halted_mask <= halted_mask | bus.halt;
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          if (any_activity || new_halt) stall_cnt <= '0;
          else if (stall_cnt != '1)     stall_cnt <= stall_cnt + 1'b1;
        end
        S_DRAIN: phase_cnt <= phase_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, never the core inputs directly.
  assign bus.cpu_rst     = (state == S_RESET);
  assign bus.run         = (state == S_RUN);
  assign bus.sim_end     = (state == S_DONE);
  assign bus.pass        = (state == S_DONE) && (status == ST_PASS);
  assign bus.status      = status;
  assign bus.cycle_count = cycle_cnt;
  assign bus.halted_mask = halted_mask;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed self-checking bench for sim_run_ctrl: reset sequence, pass, error priority,
// timeout (enabled and disabled), stall with ignored DRAIN inputs, and mid-run resets.
module tb_sim_run_ctrl;

  logic clka = 1'b0;
  logic rst  = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clka = ~clka;

  sim_run_ctrl_if #(.N_CORES(2), .CNT_W(32)) bus ();
  sim_run_ctrl_if #(.N_CORES(2), .CNT_W(32)) nt_bus ();

  sim_run_ctrl #(
    .N_CORES(2), .CNT_W(32), .RST_CYCLES(2),
    .TIMEOUT_CYCLES(300), .STALL_CYCLES(64), .DRAIN_CYCLES(4)
  ) dut (
    .clka(clka), .rst(rst), .bus(bus)
  );

  // Timeout and watchdog disabled: must keep running past 300 cycles.
  sim_run_ctrl #(
    .N_CORES(2), .CNT_W(32), .RST_CYCLES(2),
    .TIMEOUT_CYCLES(0), .STALL_CYCLES(0), .DRAIN_CYCLES(4)
  ) dut_nt (
    .clka(clka), .rst(rst), .bus(nt_bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " cpu_rst"},     bus.cpu_rst,     1);
    check({tag, " run"},         bus.run,         0);
    check({tag, " sim_end"},     bus.sim_end,     0);
    check({tag, " pass"},        bus.pass,        0);
    check({tag, " status"},      bus.status,      0);
    check({tag, " cycle_count"}, bus.cycle_count, 0);
    check({tag, " halted_mask"}, bus.halted_mask, 0);
  endtask

  // Reset for 3 clocks, release, and wait the 2 edges until RUN.
  task automatic start_run();
    @(negedge clka);
    rst = 1'b0;
    repeat (3) @(negedge clka);
    rst = 1'b1;
    repeat (2) @(negedge clka);
  endtask

  task automatic wait_cc(input int target, input string tag);
    int n = 0;
    while (bus.cycle_count != 32'(target) && n < 1000) begin
      @(negedge clka);
      n++;
    end
    check({tag, " reach cc"}, bus.cycle_count, 64'(target));
  endtask

  task automatic wait_run_end(input string tag);
    int n = 0;
    while (bus.run && n < 1000) begin
      @(negedge clka);
      n++;
    end
    check({tag, " run ended"}, bus.run, 0);
  endtask

  initial begin
    bus.halt = '0; bus.error = '0; bus.activity = '0;
    nt_bus.halt = '0; nt_bus.error = '0; nt_bus.activity = '0;

    // Reset sequence
    repeat (3) @(negedge clka);
    check_reset_vals("rst");
    rst = 1'b1;
    @(negedge clka);
    check("rst edge1 cpu_rst", bus.cpu_rst, 1);
    check("rst edge1 run",     bus.run,     0);
    @(negedge clka);
    check("rst edge2 cpu_rst", bus.cpu_rst,     0);
    check("rst edge2 run",     bus.run,         1);
    check("rst edge2 cc",      bus.cycle_count, 0);
    check("rst edge2 status",  bus.status,      0);

    // Pass: halt[0] at 10, halt[1] at 20
    wait_cc(10, "pass");
    bus.halt = 2'b01;
    @(negedge clka);
    bus.halt = 2'b00;
    check("pass mask01", bus.halted_mask, 2'b01);
    check("pass run1",   bus.run,         1);
    wait_cc(20, "pass");
    bus.halt = 2'b10;
    @(negedge clka);
    bus.halt = 2'b00;
    check("pass mask11", bus.halted_mask, 2'b11);
    check("pass status", bus.status,      1);
    check("pass cc",     bus.cycle_count, 21);
    check("pass run0",   bus.run,         0);
    repeat (3) @(negedge clka);
    check("pass sim_end early", bus.sim_end, 0);
    @(negedge clka);
    check("pass sim_end", bus.sim_end,     1);
    check("pass pass",    bus.pass,        1);
    check("pass cc held", bus.cycle_count, 21);

    // Error beats a simultaneous all-halt
    start_run();
    wait_cc(5, "err");
    bus.error = 2'b10;
    bus.halt  = 2'b11;
    @(negedge clka);
    bus.error = 2'b00;
    bus.halt  = 2'b00;
    check("err status", bus.status,      2);
    check("err cc",     bus.cycle_count, 6);
    repeat (4) @(negedge clka);
    check("err sim_end", bus.sim_end, 1);
    check("err pass",    bus.pass,    0);

    // Timeout with activity every 3 cycles; disabled-timeout twin keeps running
    start_run();
    begin
      int n = 0;
      while (bus.run && n < 400) begin
        bus.activity = (n % 3 == 0) ? 2'b01 : 2'b00;
        @(negedge clka);
        n++;
      end
    end
    bus.activity = 2'b00;
    check("to run0",    bus.run,         0);
    check("to status",  bus.status,      3);
    check("to cc",      bus.cycle_count, 300);
    check("nt run",     nt_bus.run,         1);
    check("nt cc",      nt_bus.cycle_count, 300);
    repeat (20) @(negedge clka);
    check("to sim_end", bus.sim_end, 1);
    check("to pass",    bus.pass,    0);
    check("nt run320",  nt_bus.run,         1);
    check("nt cc320",   nt_bus.cycle_count, 320);
    check("nt status",  nt_bus.status,      0);

    // Stall: activity stops at cycle_count 50; DRAIN ignores halt/error
    start_run();
    bus.activity = 2'b11;
    wait_cc(50, "stall");
    bus.activity = 2'b00;
    wait_run_end("stall");
    check("stall status", bus.status,      4);
    check("stall cc",     bus.cycle_count, 114);
    bus.halt  = 2'b11;
    bus.error = 2'b01;
    bus.activity = 2'b11;
    repeat (2) @(negedge clka);
    check("stall drain status", bus.status,      4);
    check("stall drain mask",   bus.halted_mask, 0);
    check("stall drain cc",     bus.cycle_count, 114);
    bus.halt = 2'b00; bus.error = 2'b00; bus.activity = 2'b00;
    repeat (2) @(negedge clka);
    check("stall sim_end", bus.sim_end, 1);
    check("stall pass",    bus.pass,    0);
    check("stall final",   bus.status,  4);

    // Reset during DRAIN, then in DONE, then a clean run
    start_run();
    wait_cc(3, "mid");
    bus.error = 2'b01;
    @(negedge clka);
    bus.error = 2'b00;
    check("mid drain status", bus.status, 2);
    rst = 1'b0;
    #1;
    check_reset_vals("mid drain rst");
    @(negedge clka);
    rst = 1'b1;
    repeat (2) @(negedge clka);
    check("mid run", bus.run, 1);
    bus.halt = 2'b11;
    @(negedge clka);
    bus.halt = 2'b00;
    repeat (4) @(negedge clka);
    check("mid done sim_end", bus.sim_end, 1);
    rst = 1'b0;
    #1;
    check_reset_vals("mid done rst");
    @(negedge clka);
    rst = 1'b1;
    repeat (2) @(negedge clka);
    wait_cc(7, "new");
    bus.halt = 2'b11;
    @(negedge clka);
    bus.halt = 2'b00;
    check("new status", bus.status,      1);
    check("new cc",     bus.cycle_count, 8);
    repeat (4) @(negedge clka);
    check("new sim_end", bus.sim_end, 1);
    check("new pass",    bus.pass,    1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
